// File: rtl/phi2_bus_sequencer_if.sv
// Shared-bus bundle between the PHI2 sequencer and its environment
// (CPU core pins, address decoder, aux requester, SRAM/peripheral bus).
// master = sequencer side, slave = environment side.
//   o_Phi2 / o_Phi2_Rise_En / o_Phi2_Fall_En : CPU clock and phase enables
//   o_Cpu_Rdy                                : CPU RDY pin
//   o_Mem_Sel / o_Mem_Strobe                 : port owner (1 = aux), access launch
//   o_Aux_Ack                                : aux access complete
//   i_Cpu_Valid / i_Cpu_Slow / i_Aux_Req     : CPU access, slow decode, aux request
interface phi2_bus_sequencer_if;
  logic o_Phi2;
  logic o_Phi2_Rise_En;
  logic o_Phi2_Fall_En;
  logic i_Cpu_Valid;
  logic i_Cpu_Slow;
  logic o_Cpu_Rdy;
  logic o_Mem_Sel;
  logic o_Mem_Strobe;
  logic i_Aux_Req;
  logic o_Aux_Ack;

  modport master (
    output o_Phi2, o_Phi2_Rise_En, o_Phi2_Fall_En,
    output o_Cpu_Rdy, o_Mem_Sel, o_Mem_Strobe, o_Aux_Ack,
    input  i_Cpu_Valid, i_Cpu_Slow, i_Aux_Req
  );

  modport slave (
    input  o_Phi2, o_Phi2_Rise_En, o_Phi2_Fall_En,
    input  o_Cpu_Rdy, o_Mem_Sel, o_Mem_Strobe, o_Aux_Ack,
    output i_Cpu_Valid, i_Cpu_Slow, i_Aux_Req
  );
endinterface

// File: rtl/phi2_bus_sequencer.sv
// Purpose: derives PHI2 and its phase enables from the system clock and
//   time-slices one memory port: PHI2-low half to aux, PHI2-high half to CPU.
// Latency: every output is registered off the next phase value, so an
//   output "in phase p" is high exactly while the phase counter equals p.
// Backpressure: the CPU is stalled through RDY for SLOW_WAIT PHI2 cycles on a
//   slow access; aux requests are a level, served one slot per cycle, no stall.
// Ports: i_Clk_12MHz (system clock), i_Reset (async, active high),
//   bus (phi2_bus_sequencer_if.master: PHI2/enables, RDY, memory port, aux).
module phi2_bus_sequencer #(
  parameter int CYCLE_LEN = 4,  // system clocks per PHI2 cycle, even, >= 4
  parameter int SLOW_WAIT = 2   // PHI2 cycles of RDY low per slow access, 0..7
) (
  input  logic                        i_Clk_12MHz,
  input  logic                        i_Reset,
  phi2_bus_sequencer_if.master        bus
);

  localparam int H  = CYCLE_LEN / 2;
  localparam int PW = $clog2(CYCLE_LEN);

  localparam logic [PW-1:0] PH_LAST = PW'(CYCLE_LEN - 1);
  localparam logic [PW-1:0] PH_HM1  = PW'(H - 1);
  localparam logic [PW-1:0] PH_H    = PW'(H);
  localparam logic [PW-1:0] PH_H1   = PW'(H + 1);
  localparam logic [2:0]    WAIT_LD = 3'(SLOW_WAIT);

  logic [PW-1:0] phase_q, phase_d;
  logic          phi2_q, phi2_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          sel_q, sel_d;
  logic          strobe_q, strobe_d;
  logic          ack_q, ack_d;
  logic          rdy_q, rdy_d;
  logic [2:0]    wait_q, wait_d;
  logic          done_q, done_d;

  always_comb begin
    phase_d  = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    phi2_d   = (phase_d >= PH_H);
    rise_d   = (phase_d == PH_H);
    fall_d   = (phase_d == '0);

    // Aux ownership is decided once at phase 0 and held through phase H-1.
    if (phase_d == '0) begin
      sel_d = bus.i_Aux_Req;
    end else if (phase_d < PH_H) begin
      sel_d = sel_q;
    end else begin
      sel_d = 1'b0;
    end

    strobe_d = ((phase_d == '0) && bus.i_Aux_Req) ||
               ((phase_d == PH_H) && bus.i_Cpu_Valid);
    ack_d    = (phase_d == PH_HM1) && sel_d;

    // Wait counter and done flag only move at the CPU slot edge. The done
    // flag blocks re-triggering on the cycle in which the stall releases.
    wait_d = wait_q;
    done_d = done_q;
    if (phase_d == PH_H) begin
      if (done_q) begin
        done_d = 1'b0;
      end
      if (wait_q != 3'd0) begin
        wait_d = wait_q - 3'd1;
        if (wait_q == 3'd1) begin
          done_d = 1'b1;
        end
      end else if (bus.i_Cpu_Valid && bus.i_Cpu_Slow && !done_q &&
                   (WAIT_LD != 3'd0)) begin
        wait_d = WAIT_LD;
      end
    end

    // RDY only changes one clock after the CPU slot edge, so the stall
    // window spans exactly SLOW_WAIT full PHI2 cycles.
    rdy_d = rdy_q;
    if (phase_d == PH_H1) begin
      rdy_d = (wait_q == 3'd0);
    end
  end

  always_ff @(posedge i_Clk_12MHz or posedge i_Reset) begin
    if (i_Reset) begin
      phase_q  <= '0;
      phi2_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      sel_q    <= 1'b0;
      strobe_q <= 1'b0;
      ack_q    <= 1'b0;
      rdy_q    <= 1'b1;
      wait_q   <= 3'd0;
      done_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      phi2_q   <= phi2_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sel_q    <= sel_d;
      strobe_q <= strobe_d;
      ack_q    <= ack_d;
      rdy_q    <= rdy_d;
      wait_q   <= wait_d;
      done_q   <= done_d;
    end
  end

  assign bus.o_Phi2         = phi2_q;
  assign bus.o_Phi2_Rise_En = rise_q;
  assign bus.o_Phi2_Fall_En = fall_q;
  assign bus.o_Mem_Sel      = sel_q;
  assign bus.o_Mem_Strobe   = strobe_q;
  assign bus.o_Aux_Ack      = ack_q;
  assign bus.o_Cpu_Rdy      = rdy_q;

endmodule

// File: tb/tb_phi2_bus_sequencer.sv
// Bench for phi2_bus_sequencer with CYCLE_LEN=4, SLOW_WAIT=2.
// Output vector order: {Phi2, Rise_En, Fall_En, Mem_Sel, Mem_Strobe, Aux_Ack, Cpu_Rdy}.
module tb_phi2_bus_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  phi2_bus_sequencer_if bus();

  phi2_bus_sequencer #(.CYCLE_LEN(4), .SLOW_WAIT(2)) dut (
    .i_Clk_12MHz (clk),
    .i_Reset     (rst),
    .bus         (bus)
  );

  localparam logic [6:0] V_RST = 7'b0000001;
  localparam logic [6:0] B_SEL = 7'b0001000;
  localparam logic [6:0] B_STR = 7'b0000100;
  localparam logic [6:0] B_ACK = 7'b0000010;
  localparam logic [6:0] B_RDY = 7'b0000001;

  typedef struct {
    logic [6:0] v;
    int         idx;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   ph       = 0;
  logic slot     = 1'b0;
  int   step_no  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {bus.o_Phi2, bus.o_Phi2_Rise_En, bus.o_Phi2_Fall_En, bus.o_Mem_Sel,
            bus.o_Mem_Strobe, bus.o_Aux_Ack, bus.o_Cpu_Rdy};
  endfunction

  // Idle outputs per phase: PHI2 low in 0..1, high in 2..3; Fall_En in 0, Rise_En in 2.
  function automatic logic [6:0] base(input int p);
    case (p)
      0:       return 7'b0010001;
      1:       return 7'b0000001;
      2:       return 7'b1100001;
      default: return 7'b1000001;
    endcase
  endfunction

  // Drive inputs for the next edge, then push what the outputs must be in
  // the phase that edge enters.
  task automatic step(input logic aux, input logic valid, input logic slow, input logic rdy_low);
    logic [6:0] e;
    @(negedge clk);
    bus.i_Aux_Req   = aux;
    bus.i_Cpu_Valid = valid;
    bus.i_Cpu_Slow  = slow;
    @(posedge clk);
    ph = (ph + 1) % 4;
    e  = base(ph);
    if (ph == 0) begin
      slot = aux;
      if (aux) e = e | B_SEL | B_STR;
    end
    if (ph == 1 && slot) e = e | B_SEL | B_ACK;
    if (ph == 2 && valid) e = e | B_STR;
    if (rdy_low) e = e & ~B_RDY;
    step_no++;
    #1;
    sb_q.push_back('{e, step_no});
  endtask

  task automatic idle_until(input int p);
    while (((ph + 1) % 4) != p) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check($sformatf("step%0d", e.idx), 32'(outs()), 32'(e.v));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Stall window for a slow access first seen at step index 0 (phase 2 of cycle n).
  function automatic logic rdy_low_at(input int i);
    return (i >= 1 && i <= 8);
  endfunction

  initial begin
    bus.i_Aux_Req   = 1'b0;
    bus.i_Cpu_Valid = 1'b0;
    bus.i_Cpu_Slow  = 1'b0;

    // Reset state, then release; the first phase-0 period stays at reset values.
    repeat (3) @(posedge clk);
    #1 check("reset_outs", 32'(outs()), 32'(V_RST));
    @(posedge clk);
    #1 rst = 1'b0;
    ph = 0; slot = 1'b0;
    #1 check("release_p0", 32'(outs()), 32'(V_RST));

    // Free run.
    repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Aux request rising before phase 0: single slot.
    idle_until(3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Request rising after the phase-0 sample waits; held through two samples gives two slots.
    idle_until(1);
    repeat (8) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Fast CPU accesses: strobe in every phase 2, no stall.
    idle_until(2);
    repeat (8) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Slow CPU access: RDY low for 8 clocks, no re-stall in cycle n+2.
    idle_until(2);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, rdy_low_at(i));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Slow access with aux traffic during the stall.
    idle_until(2);
    for (int i = 0; i < 12; i++) step((i >= 1 && i <= 6), 1'b1, 1'b1, rdy_low_at(i));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in phase 1 of an aux slot aborts it; pending request served after release.
    idle_until(0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("reset_mid_slot", 32'(outs()), 32'(V_RST));
    repeat (2) @(posedge clk);
    #1 check("reset_hold", 32'(outs()), 32'(V_RST));
    @(posedge clk);
    #1 rst = 1'b0;
    ph = 0; slot = 1'b0;
    #1 check("release2_p0", 32'(outs()), 32'(V_RST));
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/phi2_bus_sequencer.md
Name: phi2_bus_sequencer

Overview:
- Generates the 65C816 PHI2 clock and its single-clock phase enables from the 12 MHz system clock.
- Time-slices one shared memory port:
  - PHI2-low half goes to an auxiliary requester (DMA/video/UART buffer).
  - PHI2-high half goes to the CPU.
- Inserts CPU wait states via RDY when the CPU addresses a slow device.
- Sits between the CPU core pins, the address decoder and the external SRAM/peripheral bus.

Parameters:
- CYCLE_LEN, 4: system clocks per PHI2 cycle. Even, >= 4. H = CYCLE_LEN/2.
- SLOW_WAIT, 2: PHI2 cycles RDY is held low for a slow access. Range 0..7; 0 disables stretching.

Ports:
- i_Clk_12MHz  in  1  system clock, all logic on rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- o_Phi2  out  1  CPU clock: low for phases 0..H-1, high for phases H..CYCLE_LEN-1.
- o_Phi2_Rise_En  out  1  high during the phase-H clock only.
- o_Phi2_Fall_En  out  1  high during the phase-0 clock only.
- i_Cpu_Valid  in  1  CPU cycle is a valid memory access (VDA|VPA).
- i_Cpu_Slow  in  1  decoded CPU address targets a slow device.
- o_Cpu_Rdy  out  1  to CPU RDY pin.
- o_Mem_Sel  out  1  port owner: 0 = CPU, 1 = aux.
- o_Mem_Strobe  out  1  one-clock pulse launching a memory access.
- i_Aux_Req  in  1  aux access request, level.
- o_Aux_Ack  out  1  one-clock pulse: aux access complete.

Behaviour:
- Phase counter:
  - Counts 0..CYCLE_LEN-1 every clock and wraps.
  - All outputs are registered. The statement "asserted in phase p" means high for the clock period during which the counter equals p.
- Reset:
  - Asynchronous, clears the counter to 0.
  - Reset values: o_Phi2=0, both enables=0, o_Mem_Sel=0, o_Mem_Strobe=0, o_Aux_Ack=0, o_Cpu_Rdy=1, wait counter=0, done flag=0.
  - The first phase-0 period after release has Fall_En and Strobe suppressed.
  - Reset asserted mid-access aborts it; no Ack is issued.
- Aux slot (PHI2 low):
  - i_Aux_Req is sampled for phase 0. If high: o_Mem_Sel=1 for phases 0..H-1, o_Mem_Strobe in phase 0, o_Aux_Ack in phase H-1. o_Mem_Sel returns to 0 in phase H.
  - A request rising after the phase-0 sample waits for the next cycle.
  - A request still high at the next phase-0 sample gets another slot; the requester drops req after Ack.
  - Aux slots continue while the CPU is stalled.
- CPU slot (PHI2 high):
  - o_Mem_Sel=0 throughout.
  - If i_Cpu_Valid is sampled high for phase H, o_Mem_Strobe is asserted in phase H. This repeats every stalled cycle.
- Wait states, with slow access first seen in cycle n:
  - Trigger: i_Cpu_Valid & i_Cpu_Slow at phase H, wait counter 0, done flag 0, SLOW_WAIT>0. The counter loads SLOW_WAIT.
  - o_Cpu_Rdy is low from phase H+1 of cycle n through phase H of cycle n+SLOW_WAIT, exactly SLOW_WAIT*CYCLE_LEN clocks. This covers SLOW_WAIT PHI2 falling edges.
  - The counter decrements at each later phase H. On reaching 0, the done flag is set and Rdy returns high in phase H+1.
  - The CPU slot of cycle n+SLOW_WAIT is not re-evaluated for slowness. The done flag clears at the following phase H.
- Width: the wait counter is 3 bits and never underflows.
- Simultaneous events:
  - Aux req and CPU valid in the same PHI2 cycle are both served, each in its own half; there is no arbitration conflict.
  - A slow access with SLOW_WAIT=0 behaves as a normal access.

Test Plan:
- Free run after reset, CYCLE_LEN=4: o_Phi2 pattern 0,0,1,1 repeating; Rise_En in phase 2, Fall_En in phase 0; 3 MHz PHI2; Rdy stays 1.
- i_Aux_Req held high for one cycle before phase 0: Mem_Sel=1 in phases 0–1, Strobe in phase 0, Ack in phase 1, Mem_Sel=0 in phase 2. Req held through the next phase 0 gives a second Ack 4 clocks later.
- i_Cpu_Valid=1, i_Cpu_Slow=0: Strobe in phase 2 of every cycle; Mem_Sel=0; Rdy never drops.
- Slow access, SLOW_WAIT=2: Rdy low for exactly 8 clocks, phase 3 of cycle n to phase 2 of cycle n+2; high again in phase 3 of cycle n+2; no re-stall in cycle n+2; Strobe in phase 2 of cycles n, n+1, n+2.
- Aux req during a CPU stall: aux slots granted in cycles n+1 and n+2 with Ack each; Rdy window unchanged.
- i_Reset pulsed during phase 1 of an aux slot: outputs take reset values immediately with no Ack; after release, first Fall_En appears at the second phase-0 and the pending req is served then.
